// File: rtl/wddl_pkg.sv
// Shared types and default timing for the WDDL precharge/evaluate sequencer.
package wddl_pkg;

  localparam int unsigned PRE_CYCLES_DEF  = 1;
  localparam int unsigned EVAL_CYCLES_DEF = 2;
  localparam int unsigned ROUNDS_DEF      = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } wddl_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A counter over n values never needs fewer than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wddl_pair_checker.sv
// Sticky differential-encoding monitor for the WDDL rail pair (built only with WDDL_CHECK_EN).
module wddl_pair_checker #(
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          check_pre,
  input  logic          check_eval,
  input  logic [DW-1:0] dp_t,
  input  logic [DW-1:0] dp_f,
  output logic          err
);

  logic err_q, err_d;
  logic pre_bad, eval_bad;

  always_comb begin
    // Precharged rails must both be 0; evaluated rails must be exact complements.
    pre_bad  = check_pre && (|(dp_t | dp_f));
    eval_bad = check_eval && !(&(dp_t ^ dp_f));
    err_d    = err_q | pre_bad | eval_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate round sequencer for a WDDL datapath; WDDL_CHECK_EN adds the rail checker.
//   state | meaning
//   IDLE  | waiting for a block, rails precharged
//   PRE   | precharge phase of the current round
//   EVAL  | evaluate phase, capture on its last cycle
//   DONE  | result held until out_ready
module wddl_phase_ctrl
  import wddl_pkg::*;
#(
  parameter int unsigned PRE_CYCLES  = PRE_CYCLES_DEF,
  parameter int unsigned EVAL_CYCLES = EVAL_CYCLES_DEF,
  parameter int unsigned ROUNDS      = ROUNDS_DEF,
  parameter int unsigned DW          = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          dp_load,
  output logic          precharge,
  output logic          dp_capture,
  output logic [3:0]    round_idx,
  output logic          round_last,
  input  logic [DW-1:0] dp_t,
  input  logic [DW-1:0] dp_f,
  output logic          wddl_err
);

  localparam int unsigned CW = cnt_width(max2(PRE_CYCLES, EVAL_CYCLES));
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST  = CW'(EVAL_CYCLES - 1);
  localparam logic [3:0]    ROUND_LAST = 4'(ROUNDS - 1);

  wddl_state_e   state_q, state_d;
  logic [CW-1:0] phase_cnt_q, phase_cnt_d;
  logic [3:0]    round_q, round_d;
  logic          precharge_q, precharge_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_cnt_q <= '0;
      round_q     <= '0;
      precharge_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      round_q     <= round_d;
      precharge_q <= precharge_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    round_d     = round_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dp_load     = 1'b0;
    dp_capture  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        dp_load  = in_valid;
        if (in_valid) begin
          state_d     = ST_PRE;
          phase_cnt_d = '0;
          round_d     = '0;
        end
      end
      ST_PRE: begin
        if (phase_cnt_q == PRE_LAST) begin
          state_d     = ST_EVAL;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + CW'(1);
        end
      end
      ST_EVAL: begin
        if (phase_cnt_q == EVAL_LAST) begin
          dp_capture  = 1'b1;
          phase_cnt_d = '0;
          // round_idx only names a live round, so it drops back to 0 in DONE.
          if (round_q == ROUND_LAST) begin
            state_d = ST_DONE;
            round_d = '0;
          end else begin
            state_d = ST_PRE;
            round_d = round_q + 4'd1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so the rail-forcing signal never glitches.
    precharge_d = (state_d != ST_EVAL);
  end

  assign precharge  = precharge_q;
  assign round_idx  = round_q;
  assign round_last = (round_q == ROUND_LAST);

`ifdef WDDL_CHECK_EN
  logic pre_last;
  assign pre_last = (state_q == ST_PRE) && (phase_cnt_q == PRE_LAST);

  wddl_pair_checker #(
    .DW(DW)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .check_pre  (pre_last),
    .check_eval (dp_capture),
    .dp_t       (dp_t),
    .dp_f       (dp_f),
    .err        (wddl_err)
  );
`else
  logic unused_rails;
  assign unused_rails = ^{dp_t, dp_f};
  assign wddl_err     = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Bench for wddl_phase_ctrl: default instance plus a PRE=2/EVAL=1/ROUNDS=1 instance, both against a timeline model.
`timescale 1ns/1ps
module tb_wddl_phase_ctrl;

  localparam int A_P = 1, A_E = 2, A_R = 10, A_DW = 128;
  localparam int B_P = 2, B_E = 1, B_R = 1,  B_DW = 8;
`ifdef WDDL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready;
  logic [A_DW-1:0] a_t, a_f;
  logic [B_DW-1:0] b_t, b_f;
  logic a_in_ready, a_out_valid, a_dp_load, a_precharge, a_dp_capture, a_round_last, a_wddl_err;
  logic b_in_ready, b_out_valid, b_dp_load, b_precharge, b_dp_capture, b_round_last, b_wddl_err;
  logic [3:0] a_round_idx, b_round_idx;

  wddl_phase_ctrl u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready), .dp_load(a_dp_load),
    .precharge(a_precharge), .dp_capture(a_dp_capture), .round_idx(a_round_idx),
    .round_last(a_round_last), .dp_t(a_t), .dp_f(a_f), .wddl_err(a_wddl_err)
  );

  wddl_phase_ctrl #(
    .PRE_CYCLES(B_P), .EVAL_CYCLES(B_E), .ROUNDS(B_R), .DW(B_DW)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready), .dp_load(b_dp_load),
    .precharge(b_precharge), .dp_capture(b_dp_capture), .round_idx(b_round_idx),
    .round_last(b_round_last), .dp_t(b_t), .dp_f(b_f), .wddl_err(b_wddl_err)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0, rail_fault = 1'b0, rec = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Model: a block is just "cycles elapsed since accept"; phase and round follow by division.
  int P[2] = '{A_P, B_P};
  int E[2] = '{A_E, B_E};
  int R[2] = '{A_R, B_R};
  bit m_busy[2] = '{1'b0, 1'b0};
  int m_age[2]  = '{0, 0};
  bit m_err[2]  = '{1'b0, 1'b0};

  typedef struct {
    bit in_ready, out_valid, dp_load, precharge, dp_capture, round_last, err;
    int round_idx;
  } exp_t;

  function automatic int tdone(input int i);
    return R[i] * (P[i] + E[i]) + 1;
  endfunction

  function automatic exp_t expect_of(input int i);
    exp_t e;
    int k, ph;
    e.in_ready = 0; e.out_valid = 0; e.dp_load = 0; e.precharge = 1;
    e.dp_capture = 0; e.round_idx = 0;
    e.err = CHK && m_err[i];
    if (!m_busy[i]) begin
      e.in_ready = 1;
      e.dp_load  = in_valid;
    end else if (m_age[i] == tdone(i)) begin
      e.out_valid = 1;
    end else begin
      k  = m_age[i] - 1;
      ph = k % (P[i] + E[i]);
      e.round_idx  = k / (P[i] + E[i]);
      e.precharge  = (ph < P[i]);
      e.dp_capture = (ph == P[i] + E[i] - 1);
    end
    e.round_last = (e.round_idx == R[i] - 1);
    return e;
  endfunction

  function automatic bit rail_hit(input int i, input bit any_set, input bit any_equal);
    int ph;
    if (!m_busy[i] || m_age[i] >= tdone(i)) return 1'b0;
    ph = (m_age[i] - 1) % (P[i] + E[i]);
    return ((ph == P[i] - 1) && any_set) || ((ph == P[i] + E[i] - 1) && any_equal);
  endfunction

  task automatic model_step(input int i, input bit any_set, input bit any_equal);
    if (rst) begin
      m_busy[i] = 0; m_age[i] = 0; m_err[i] = 0;
    end else begin
      if (rail_hit(i, any_set, any_equal)) m_err[i] = 1;
      if (!m_busy[i]) begin
        if (in_valid) begin m_busy[i] = 1; m_age[i] = 1; end
      end else if (m_age[i] == tdone(i)) begin
        if (out_ready) m_busy[i] = 0;
      end else begin
        m_age[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, |(a_t | a_f), ~&(a_t ^ a_f));
    model_step(1, |(b_t | b_f), ~&(b_t ^ b_f));
    cyc++;
  end

  // Rails: all-zero while precharged, random complementary pairs while evaluating.
  always begin : rail_drv
    exp_t ea, eb;
    @(posedge clk);
    #1;
    ea = expect_of(0);
    eb = expect_of(1);
    if (ea.precharge || (rail_fault && ea.dp_capture)) begin
      a_t = '0; a_f = '0;
    end else begin
      a_t = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_f = ~a_t;
    end
    if (eb.precharge || (rail_fault && eb.dp_capture)) begin
      b_t = '0; b_f = '0;
    end else begin
      b_t = B_DW'($urandom());
      b_f = ~b_t;
    end
  end

  always @(negedge clk) begin : compare
    exp_t ea, eb;
    if (chk_en) begin
      ea = expect_of(0);
      eb = expect_of(1);
      cmp("a_in_ready",   a_in_ready,   ea.in_ready);
      cmp("a_out_valid",  a_out_valid,  ea.out_valid);
      cmp("a_dp_load",    a_dp_load,    ea.dp_load);
      cmp("a_precharge",  a_precharge,  ea.precharge);
      cmp("a_dp_capture", a_dp_capture, ea.dp_capture);
      cmp("a_round_idx",  a_round_idx,  ea.round_idx);
      cmp("a_round_last", a_round_last, ea.round_last);
      cmp("a_wddl_err",   a_wddl_err,   ea.err);
      cmp("b_in_ready",   b_in_ready,   eb.in_ready);
      cmp("b_out_valid",  b_out_valid,  eb.out_valid);
      cmp("b_dp_load",    b_dp_load,    eb.dp_load);
      cmp("b_precharge",  b_precharge,  eb.precharge);
      cmp("b_dp_capture", b_dp_capture, eb.dp_capture);
      cmp("b_round_idx",  b_round_idx,  eb.round_idx);
      cmp("b_round_last", b_round_last, eb.round_last);
      cmp("b_wddl_err",   b_wddl_err,   eb.err);
    end
  end

  int a_load_q[$], a_cap_q[$], a_rl_q[$], b_low_q[$], b_cap_q[$];
  int a_ov_first = -1, b_ov_first = -1;

  always @(negedge clk) begin
    if (rec) begin
      if (a_dp_load)    a_load_q.push_back(cyc);
      if (a_dp_capture) a_cap_q.push_back(cyc);
      if (a_round_last) a_rl_q.push_back(cyc);
      if (a_out_valid && a_ov_first < 0) a_ov_first = cyc;
      if (!b_precharge) b_low_q.push_back(cyc);
      if (b_dp_capture) b_cap_q.push_back(cyc);
      if (b_out_valid && b_ov_first < 0) b_ov_first = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_idle();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && !a_in_ready; n++) step();
    cmp("wait_a_idle", a_in_ready, 1);
    out_ready = 1'b0;
  endtask

  int exp_cap[10] = '{3, 6, 9, 12, 15, 18, 21, 24, 27, 30};
  int c0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_t = '0; a_f = '0; b_t = '0; b_f = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    cmp("rst_in_ready",   a_in_ready,   1);
    cmp("rst_precharge",  a_precharge,  1);
    cmp("rst_out_valid",  a_out_valid,  0);
    cmp("rst_dp_capture", a_dp_capture, 0);
    cmp("rst_round_idx",  a_round_idx,  0);
    cmp("rst_round_last", a_round_last, 0);
    cmp("rst_b_round_last", b_round_last, 1);
    cmp("rst_wddl_err",   a_wddl_err,   0);

    // Single block on both instances, result held back for five cycles.
    rec = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !a_out_valid; n++) step();
    cmp("wait_out_valid", a_out_valid, 1);
    for (int n = 0; n < 5; n++) begin
      step();
      cmp("hold_out_valid", a_out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cmp("release_in_ready",  a_in_ready,  1);
    cmp("release_out_valid", a_out_valid, 0);
    rec = 1'b0;

    cmp("load_count", a_load_q.size(), 1);
    c0 = (a_load_q.size() > 0) ? a_load_q[0] : 0;
    cmp("cap_count", a_cap_q.size(), 10);
    for (int j = 0; j < 10 && j < a_cap_q.size(); j++)
      cmp("cap_cycle", a_cap_q[j] - c0, exp_cap[j]);
    cmp("out_valid_cycle", a_ov_first - c0, 31);
    cmp("round_last_count", a_rl_q.size(), 3);
    if (a_rl_q.size() > 0) begin
      cmp("round_last_first", a_rl_q[0] - c0, 28);
      cmp("round_last_final", a_rl_q[a_rl_q.size()-1] - c0, 30);
    end
    cmp("b_low_count", b_low_q.size(), 1);
    if (b_low_q.size() > 0) cmp("b_low_cycle", b_low_q[0] - c0, 3);
    cmp("b_cap_count", b_cap_q.size(), 1);
    if (b_cap_q.size() > 0) cmp("b_cap_cycle", b_cap_q[0] - c0, 3);
    cmp("b_out_valid_cycle", b_ov_first - c0, 4);

    // in_valid held high: one load per block, blocks 32 cycles apart.
    a_load_q.delete();
    rec = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 97; n++) step();
    in_valid = 1'b0;
    rec = 1'b0;
    cmp("b2b_load_count", a_load_q.size(), 4);
    for (int j = 1; j < a_load_q.size(); j++)
      cmp("b2b_spacing", a_load_q[j] - a_load_q[j-1], 32);
    wait_a_idle();

    // Reset in the middle of round 4 evaluate.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !(a_round_idx == 4'd4 && !a_precharge); n++) step();
    cmp("reach_round4_eval", a_round_idx, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("midrst_in_ready",  a_in_ready,  1);
    cmp("midrst_precharge", a_precharge, 1);
    cmp("midrst_round_idx", a_round_idx, 0);
    cmp("midrst_out_valid", a_out_valid, 0);

    // Random traffic with occasional resets; rails always well formed.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    cmp("err_clean", a_wddl_err, 0);
    wait_a_idle();

    // Collapsed rails at a capture set the sticky error (checker builds only).
    rail_fault = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !a_dp_capture; n++) @(negedge clk);
    cmp("fault_capture_seen", a_dp_capture, 1);
    rail_fault = 1'b0;
    step();
    step();
    cmp("err_set", a_wddl_err, CHK);
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) step();
    cmp("err_sticky", a_wddl_err, CHK);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp("err_cleared", a_wddl_err, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
